// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
// Shared definitions for the approximate-multiplier arbiter slice.
//   OPW            operand width (8 bits)
//   PW             product width (16 bits)
//   operand_t      one captured request operand set (x, y, exact)
//   approx_product truncated 8x8 product with a small carry correction
package approx_mult_pkg;

  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef struct packed {
    logic [OPW-1:0] x;
    logic [OPW-1:0] y;
    logic           exact;
  } operand_t;

  // Drops the two low multiplicand bits from the main partial-product array
  // and puts back only the most significant cross terms of those bits, so
  // large products keep their top bits while small ones lose accuracy.
  function automatic logic [PW-1:0] approx_product(input logic [OPW-1:0] x,
                                                   input logic [OPW-1:0] y);
    logic [PW-1:0] partial;
    logic [PW-1:0] carry_fix;
    logic [PW-1:0] top_fix;
    partial   = (PW'(y) * PW'(x[OPW-1:2])) << 2;
    carry_fix = (PW'(x[0] & y[OPW-1]) + PW'(x[1] & y[OPW-2])) << 7;
    top_fix   = PW'(x[1] & y[OPW-1]) << 8;
    return partial + carry_fix + top_fix;
  endfunction

endpackage

// File: rtl/approx_mult_core.sv
// approx_mult_core
// Purely combinational 8x8 multiplier with a per-operation mode select.
//   x      in   8   multiplicand
//   y      in   8   multiplier
//   exact  in   1   1 = exact product, 0 = approximate product
//   z      out  16  product
module approx_mult_core
  import approx_mult_pkg::*;
(
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  input  logic           exact,
  output logic [PW-1:0]  z
);

  assign z = exact ? (PW'(x) * PW'(y)) : approx_product(x, y);

endmodule

// File: rtl/approx_mult_arbiter.sv
// approx_mult_arbiter
// Round-robin arbiter feeding one shared two-stage multiplier pipeline.
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     per-requester operand valid
//   req_ready  out  NREQ     per-requester grant/accept
//   req_x      in   8*NREQ   multiplicands, requester i at [8i+7:8i]
//   req_y      in   8*NREQ   multipliers, same packing
//   req_exact  in   NREQ     per-request mode, 1 = exact
//   out_valid  out  1        result valid
//   out_ready  in   1        downstream accept
//   out_z      out  16       product
//   out_id     out  IDW      originating requester
//   busy       out  1        any pipeline stage occupied
//   acc_cnt    out  16       wrapping count of accepted requests
// Stage 1 holds captured operands; stage 2 is the registered output, so
// out_* never see req_* combinationally.
module approx_mult_arbiter
  import approx_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_x,
  input  logic [OPW*NREQ-1:0] req_y,
  input  logic [NREQ-1:0]     req_exact,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PW-1:0]       out_z,
  output logic [IDW-1:0]      out_id,
  output logic                busy,
  output logic [15:0]         acc_cnt
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  operand_t       s1_op;
  logic           s1_valid;
  logic [IDW-1:0] s1_id;

  logic           s2_load;
  logic           s1_open;
  logic           req_fire;
  logic [PW-1:0]  core_z;

  // Rotating priority search: candidates are visited starting at ptr and
  // wrapped back into 0..NREQ-1 with one extra bit of headroom, so non
  // power-of-two NREQ values work too.
  always_comb begin
    logic [IDW:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Pointer moves to the slot just after the winner.
  always_comb begin
    logic [IDW:0] inc;
    inc = {1'b0, grant_idx} + (IDW+1)'(1);
    if (inc >= (IDW+1)'(NREQ)) begin
      inc = '0;
    end
    ptr_next = inc[IDW-1:0];
  end

  // Stage 1 may take a new request when it is empty or draining this cycle.
  assign s2_load = s1_valid & (~out_valid | out_ready);
  assign s1_open = ~s1_valid | s2_load;

  // rst_n gating keeps every grant low for the whole reset period.
  always_comb begin
    req_ready = '0;
    if (rst_n && s1_open && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign req_fire = |(req_ready & req_valid);

  // Arbitration pointer and stage 1 operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
    end else begin
      if (req_fire) begin
        ptr         <= ptr_next;
        s1_valid    <= 1'b1;
        s1_op.x     <= req_x[OPW*grant_idx +: OPW];
        s1_op.y     <= req_y[OPW*grant_idx +: OPW];
        s1_op.exact <= req_exact[grant_idx];
        s1_id       <= grant_idx;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  approx_mult_core u_core (
    .x     (s1_op.x),
    .y     (s1_op.y),
    .exact (s1_op.exact),
    .z     (core_z)
  );

  // Output stage: a load replaces the held result directly, so a consumed
  // result and a fresh one swap in the same cycle without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_id    <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        out_z     <= core_z;
        out_id    <= s1_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (req_fire) begin
      acc_cnt <= acc_cnt + 16'd1;
    end
  end

  assign busy = s1_valid | out_valid;

endmodule

// File: tb/tb_approx_mult_arbiter.sv
// tb_approx_mult_arbiter
// Directed self-checking bench for approx_mult_arbiter (NREQ = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_approx_mult_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_exact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [1:0]  out_id;
  logic        busy;
  logic [15:0] acc_cnt;

  int          checks;
  int          failures;
  logic [15:0] exp_acc;

  approx_mult_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_exact (req_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_id    (out_id),
    .busy      (busy),
    .acc_cnt   (acc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
    req_valid = valid;
    out_ready = rdy;
  endtask

  // One isolated request from requester r; result expected one edge after
  // the accepting edge, then the pipeline must empty.
  task automatic runSingle(input int r, input logic [7:0] x, input logic [7:0] y,
                           input logic e, input logic [15:0] expz, input string tag);
    req_x[8*r +: 8] = x;
    req_y[8*r +: 8] = y;
    req_exact[r]    = e;
    applyStimulus(4'b0001 << r, 1'b1);
    #1;
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << r));
    @(posedge clk); #1;
    applyStimulus(4'b0000, 1'b1);
    exp_acc = exp_acc + 16'd1;
    checkOutput({tag, "_s1_outvalid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_s1_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_acc"}, 32'(acc_cnt), 32'(exp_acc));
    @(posedge clk); #1;
    checkOutput({tag, "_outvalid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_z"}, 32'(out_z), 32'(expz));
    checkOutput({tag, "_id"}, 32'(out_id), 32'(r));
    @(posedge clk); #1;
    checkOutput({tag, "_drained"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_acc  = 16'd0;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_x     = '0;
    req_y     = '0;
    req_exact = '0;
    out_ready = 1'b1;
    $display("[TB] reset checks");
    #3;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_z", 32'(out_z), 32'd0);
    checkOutput("rst_out_id", 32'(out_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acc", 32'(acc_cnt), 32'd0);
    req_valid = 4'h0;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_ready", 32'(req_ready), 32'd0);

    // Single-request products, hand-computed.
    runSingle(0, 8'hFF, 8'hFF, 1'b0, 16'hFD04, "ff_approx");
    runSingle(0, 8'hFF, 8'hFF, 1'b1, 16'hFE01, "ff_exact");
    runSingle(2, 8'h03, 8'h80, 1'b0, 16'h0180, "x3y80_approx");
    runSingle(3, 8'h03, 8'h7F, 1'b0, 16'h0080, "x3y7f_approx");
    runSingle(1, 8'h03, 8'h7F, 1'b1, 16'h017D, "x3y7f_exact");

    // All requesters carry x = i+1, y = 0x10, exact: product is (i+1)*16.
    for (int i = 0; i < 4; i++) begin
      req_x[8*i +: 8] = 8'(i + 1);
      req_y[8*i +: 8] = 8'h10;
    end
    req_exact = 4'hF;

    // Stall: pointer sits at 2, so requesters 2 and 3 fill both stages.
    $display("[TB] output stall");
    applyStimulus(4'hF, 1'b0);
    #1;
    checkOutput("stall_ready0", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    exp_acc = exp_acc + 16'd1;
    checkOutput("stall_ready1", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    exp_acc = exp_acc + 16'd1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("stall_ready_low", 32'(req_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_out_z", 32'(out_z), 32'h0030);
      checkOutput("stall_out_id", 32'(out_id), 32'd2);
      checkOutput("stall_acc", 32'(acc_cnt), 32'(exp_acc));
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    applyStimulus(4'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("drain_valid", 32'(out_valid), 32'd1);
    checkOutput("drain_z", 32'(out_z), 32'h0040);
    checkOutput("drain_id", 32'(out_id), 32'd3);
    @(posedge clk); #1;
    checkOutput("drain_empty", 32'(busy), 32'd0);
    checkOutput("drain_acc", 32'(acc_cnt), 32'(exp_acc));

    // Reset while busy, then round-robin from requester 0.
    $display("[TB] reset while busy");
    applyStimulus(4'hF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_acc", 32'(acc_cnt), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd0);
    exp_acc = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int t = 0; t < 8; t++) begin
      checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << (t % 4)));
      @(posedge clk); #1;
      exp_acc = exp_acc + 16'd1;
      if (t == 0) begin
        checkOutput("rr_latency", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("rr_out_valid", 32'(out_valid), 32'd1);
        checkOutput("rr_out_id", 32'(out_id), 32'((t - 1) % 4));
        checkOutput("rr_out_z", 32'(out_z), 32'((((t - 1) % 4) + 1) * 16));
      end
    end
    applyStimulus(4'h0, 1'b1);
    @(posedge clk); #1;
    checkOutput("rr_last_id", 32'(out_id), 32'd3);
    checkOutput("rr_last_z", 32'(out_z), 32'h0040);
    checkOutput("rr_acc", 32'(acc_cnt), 32'(exp_acc));
    @(posedge clk); #1;
    checkOutput("rr_empty", 32'(busy), 32'd0);

    // Counter wrap: one accept per cycle up to 0xFFFF, then one more.
    $display("[TB] counter wrap");
    applyStimulus(4'hF, 1'b1);
    repeat (65535 - 8) @(posedge clk);
    #1;
    exp_acc = exp_acc + 16'd65527;
    checkOutput("acc_max", 32'(acc_cnt), 32'(exp_acc));
    @(posedge clk); #1;
    applyStimulus(4'h0, 1'b1);
    exp_acc = exp_acc + 16'd1;
    checkOutput("acc_wrap", 32'(acc_cnt), 32'(exp_acc));
    checkOutput("acc_wrap_zero", 32'(acc_cnt), 32'd0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
